// File: rtl/clk_alarm_multi.sv
// BCD time-of-day clock with N_ALARM programmable alarm channels and a
// ring / snooze / dismiss controller with an auto-stop ring timer.
module clk_alarm_multi #(
  parameter int unsigned CNT_MAX    = 49999999,
  parameter int unsigned N_ALARM    = 4,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               load,
  input  logic [23:0]        time_in,
  input  logic               alarm_we,
  input  logic [2:0]         alarm_idx,
  input  logic [23:0]        alarm_time,
  input  logic               alarm_en_in,
  input  logic               snooze,
  input  logic               dismiss,
  output logic [23:0]        time_out,
  output logic               tick,
  output logic               buzzer,
  output logic [N_ALARM-1:0] alarm_hit,
  output logic               load_err
);

  localparam int unsigned PW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam int unsigned RW = (RING_SEC > 0) ? $clog2(RING_SEC + 1) : 1;
  localparam int unsigned SW = (SNOOZE_SEC > 0) ? $clog2(SNOOZE_SEC + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_e;

  logic [PW-1:0]      presc_q;
  logic               sec_end_c;
  logic               load_ok_c;
  logic [23:0]        time_inc_c;
  logic [3:0]         d_h10, d_h1, d_m10, d_m1, d_s10, d_s1;
  logic [3:0]         n_h10, n_h1, n_m10, n_m1, n_s10, n_s1;
  logic [23:0]        alarm_val [N_ALARM];
  logic [N_ALARM-1:0] alarm_en;
  logic [N_ALARM-1:0] match_c;
  state_e             state_q, state_d;
  logic [RW-1:0]      ring_q, ring_d;
  logic [SW-1:0]      snz_q, snz_d;
  logic [N_ALARM-1:0] hit_d;
  logic               buzzer_d;

  assign {d_h10, d_h1, d_m10, d_m1, d_s10, d_s1} = time_out;
  assign sec_end_c = run && (presc_q == PW'(CNT_MAX));

  // A load is legal only when it names a real time of day.
  assign load_ok_c = ((time_in[23:20] < 4'd2 && time_in[19:16] <= 4'd9) ||
                      (time_in[23:20] == 4'd2 && time_in[19:16] <= 4'd3)) &&
                     (time_in[15:12] <= 4'd5) && (time_in[11:8] <= 4'd9) &&
                     (time_in[7:4]   <= 4'd5) && (time_in[3:0]  <= 4'd9);

  // One-second BCD increment with ripple carry through the digits.
  always_comb begin
    n_h10 = d_h10;
    n_h1  = d_h1;
    n_m10 = d_m10;
    n_m1  = d_m1;
    n_s10 = d_s10;
    n_s1  = d_s1;
    if (d_s1 != 4'd9) begin
      n_s1 = d_s1 + 4'd1;
    end else begin
      n_s1 = 4'd0;
      if (d_s10 != 4'd5) begin
        n_s10 = d_s10 + 4'd1;
      end else begin
        n_s10 = 4'd0;
        if (d_m1 != 4'd9) begin
          n_m1 = d_m1 + 4'd1;
        end else begin
          n_m1 = 4'd0;
          if (d_m10 != 4'd5) begin
            n_m10 = d_m10 + 4'd1;
          end else begin
            n_m10 = 4'd0;
            if (d_h10 == 4'd2 && d_h1 == 4'd3) begin
              n_h10 = 4'd0;
              n_h1  = 4'd0;
            end else if (d_h1 == 4'd9) begin
              n_h1  = 4'd0;
              n_h10 = d_h10 + 4'd1;
            end else begin
              n_h1 = d_h1 + 4'd1;
            end
          end
        end
      end
    end
    time_inc_c = {n_h10, n_h1, n_m10, n_m1, n_s10, n_s1};
  end

  // Prescaler and time registers; an accepted load overrides the advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      time_out <= '0;
      tick     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tick     <= 1'b0;
      load_err <= 1'b0;
      if (load && load_ok_c) begin
        time_out <= time_in;
        presc_q  <= '0;
      end else begin
        load_err <= load;
        if (run) begin
          if (sec_end_c) begin
            presc_q  <= '0;
            time_out <= time_inc_c;
            tick     <= 1'b1;
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
      end
    end
  end

  // Alarm channel storage; indices beyond N_ALARM fall through the loop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_ALARM); i++) begin
        alarm_val[i] <= '0;
      end
      alarm_en <= '0;
    end else if (alarm_we) begin
      for (int i = 0; i < int'(N_ALARM); i++) begin
        if (alarm_idx == 3'(i)) begin
          alarm_val[i] <= alarm_time;
          alarm_en[i]  <= alarm_en_in;
        end
      end
    end
  end

  // Illegal stored values never equal time_out, so they cannot match.
  always_comb begin
    match_c = '0;
    for (int i = 0; i < int'(N_ALARM); i++) begin
      match_c[i] = tick && alarm_en[i] && (alarm_val[i] == time_out);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ring_q    <= '0;
      snz_q     <= '0;
      alarm_hit <= '0;
      buzzer    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ring_q    <= ring_d;
      snz_q     <= snz_d;
      alarm_hit <= hit_d;
      buzzer    <= buzzer_d;
    end
  end

  // Ring controller: dismiss beats snooze beats the auto-stop timeout.
  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    snz_d   = snz_q;
    hit_d   = alarm_hit | match_c;
    unique case (state_q)
      IDLE: begin
        if (|match_c) begin
          state_d = RING;
          ring_d  = RW'(RING_SEC);
        end
      end
      RING: begin
        if (dismiss) begin
          state_d = IDLE;
          hit_d   = '0;
        end else if (snooze) begin
          state_d = SNOOZE;
          snz_d   = SW'(SNOOZE_SEC);
        end else if (tick) begin
          if (ring_q <= RW'(1)) begin
            state_d = IDLE;
            hit_d   = '0;
          end else begin
            ring_d = ring_q - RW'(1);
          end
        end
      end
      SNOOZE: begin
        if (dismiss) begin
          state_d = IDLE;
          hit_d   = '0;
        end else if (|match_c) begin
          state_d = RING;
          ring_d  = RW'(RING_SEC);
        end else if (tick) begin
          if (snz_q <= SW'(1)) begin
            state_d = RING;
            ring_d  = RW'(RING_SEC);
          end else begin
            snz_d = snz_q - SW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        hit_d   = '0;
      end
    endcase
    buzzer_d = (state_d == RING);
  end

endmodule

// File: tb/tb_clk_alarm_multi.sv
// Bench for clk_alarm_multi: directed scenarios then random traffic, all
// checked every cycle against a seconds-based behavioural model.
module tb_clk_alarm_multi;

  localparam int unsigned CNT_MAX    = 3;
  localparam int unsigned N_ALARM    = 4;
  localparam int unsigned RING_SEC   = 4;
  localparam int unsigned SNOOZE_SEC = 3;
  localparam int          DAY        = 86400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        load = 1'b0;
  logic [23:0] time_in = '0;
  logic        alarm_we = 1'b0;
  logic [2:0]  alarm_idx = '0;
  logic [23:0] alarm_time = '0;
  logic        alarm_en_in = 1'b0;
  logic        snooze = 1'b0;
  logic        dismiss = 1'b0;
  logic [23:0] time_out;
  logic        tick;
  logic        buzzer;
  logic [3:0]  alarm_hit;
  logic        load_err;

  clk_alarm_multi #(
    .CNT_MAX(CNT_MAX), .N_ALARM(N_ALARM), .RING_SEC(RING_SEC), .SNOOZE_SEC(SNOOZE_SEC)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .load(load), .time_in(time_in),
    .alarm_we(alarm_we), .alarm_idx(alarm_idx), .alarm_time(alarm_time),
    .alarm_en_in(alarm_en_in), .snooze(snooze), .dismiss(dismiss),
    .time_out(time_out), .tick(tick), .buzzer(buzzer), .alarm_hit(alarm_hit),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: time as seconds since midnight, alarms as seconds (-1 = never).
  typedef enum {M_IDLE, M_RING, M_SNOOZE} mode_e;
  int         m_sec, m_pre, m_ring_ticks, m_snz_ticks;
  bit         m_tick, m_err, m_buzz;
  logic [3:0] m_hit;
  int         m_alarm [N_ALARM];
  bit         m_en [N_ALARM];
  mode_e      m_mode;

  function automatic logic [23:0] to_bcd(input int s);
    int h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic int from_bcd(input logic [23:0] b);
    int h, m, s;
    h = int'(b[23:20]) * 10 + int'(b[19:16]);
    m = int'(b[15:12]) * 10 + int'(b[11:8]);
    s = int'(b[7:4]) * 10 + int'(b[3:0]);
    if (b[19:16] > 4'd9 || b[15:12] > 4'd5 || b[11:8] > 4'd9 ||
        b[7:4] > 4'd5 || b[3:0] > 4'd9 || h > 23)
      return -1;
    return h * 3600 + m * 60 + s;
  endfunction

  task automatic model_reset();
    m_sec = 0; m_pre = 0; m_tick = 0; m_err = 0; m_buzz = 0;
    m_hit = '0; m_mode = M_IDLE; m_ring_ticks = 0; m_snz_ticks = 0;
    for (int i = 0; i < int'(N_ALARM); i++) begin
      m_alarm[i] = 0;
      m_en[i]    = 0;
    end
  endtask

  task automatic model_edge();
    logic [3:0] match;
    int t;
    match = '0;
    for (int i = 0; i < int'(N_ALARM); i++)
      if (m_tick && m_en[i] && m_alarm[i] == m_sec) match[i] = 1'b1;
    case (m_mode)
      M_IDLE: if (match != 0) begin m_mode = M_RING; m_ring_ticks = 0; m_hit = match; end
      M_RING: begin
        m_hit |= match;
        if (dismiss) begin m_mode = M_IDLE; m_hit = '0; end
        else if (snooze) begin m_mode = M_SNOOZE; m_snz_ticks = 0; end
        else if (m_tick) begin
          m_ring_ticks++;
          if (m_ring_ticks == int'(RING_SEC)) begin m_mode = M_IDLE; m_hit = '0; end
        end
      end
      default: begin
        m_hit |= match;
        if (dismiss) begin m_mode = M_IDLE; m_hit = '0; end
        else if (match != 0) begin m_mode = M_RING; m_ring_ticks = 0; end
        else if (m_tick) begin
          m_snz_ticks++;
          if (m_snz_ticks == int'(SNOOZE_SEC)) begin m_mode = M_RING; m_ring_ticks = 0; end
        end
      end
    endcase
    m_buzz = (m_mode == M_RING);
    if (alarm_we && int'(alarm_idx) < int'(N_ALARM)) begin
      m_alarm[alarm_idx] = from_bcd(alarm_time);
      m_en[alarm_idx]    = alarm_en_in;
    end
    t = from_bcd(time_in);
    m_err  = 0;
    m_tick = 0;
    if (load && t >= 0) begin
      m_sec = t;
      m_pre = 0;
    end else begin
      m_err = load;
      if (run) begin
        if (m_pre == int'(CNT_MAX)) begin
          m_pre  = 0;
          m_sec  = (m_sec + 1) % DAY;
          m_tick = 1;
        end else begin
          m_pre++;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: model and DUT both take the edge, then every output is compared.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("time_out", time_out, to_bcd(m_sec));
    chk("tick", 24'(tick), 24'(m_tick));
    chk("buzzer", 24'(buzzer), 24'(m_buzz));
    chk("alarm_hit", 24'(alarm_hit), 24'(m_hit));
    chk("load_err", 24'(load_err), 24'(m_err));
    @(negedge clk);
    load = 1'b0; alarm_we = 1'b0; snooze = 1'b0; dismiss = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    load = 1'b0; alarm_we = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_time", time_out, 24'h0);
    chk("rst_tick", 24'(tick), 24'h0);
    chk("rst_buzzer", 24'(buzzer), 24'h0);
    chk("rst_hit", 24'(alarm_hit), 24'h0);
    chk("rst_load_err", 24'(load_err), 24'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_alarm(input int idx, input logic [23:0] t, input logic en);
    alarm_we = 1'b1; alarm_idx = 3'(idx); alarm_time = t; alarm_en_in = en;
    cyc();
  endtask

  task automatic do_load(input logic [23:0] t);
    load = 1'b1; time_in = t;
    cyc();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("init_time", time_out, 24'h0);
    chk("init_buzzer", 24'(buzzer), 24'h0);
    chk("init_hit", 24'(alarm_hit), 24'h0);
    chk("init_tick", 24'(tick), 24'h0);
    rst = 1'b0;

    // Midnight rollover and tick period.
    do_load(24'h235958);
    chk("load_ok", time_out, 24'h235958);
    run = 1'b1;
    cycles(4);
    chk("first_tick", 24'(tick), 24'h1);
    chk("sec_59", time_out, 24'h235959);
    cycles(4);
    chk("rollover", time_out, 24'h000000);
    run = 1'b0;

    // Rejected and accepted loads.
    do_load(24'h246000);
    chk("bad_load_err", 24'(load_err), 24'h1);
    chk("bad_load_time", time_out, 24'h000000);
    cyc();
    chk("load_err_pulse", 24'(load_err), 24'h0);
    do_load(24'h123059);
    chk("good_load", time_out, 24'h123059);

    // Alarm fire and auto-stop.
    set_alarm(2, 24'h000005, 1'b1);
    do_load(24'h000003);
    run = 1'b1;
    cycles(8);
    chk("match_tick", 24'(tick), 24'h1);
    chk("match_time", time_out, 24'h000005);
    chk("pre_ring_buzzer", 24'(buzzer), 24'h0);
    cyc();
    chk("ring_buzzer", 24'(buzzer), 24'h1);
    chk("ring_hit", 24'(alarm_hit), 24'h4);
    cycles(15);
    chk("ring_hold", 24'(buzzer), 24'h1);
    cyc();
    chk("autostop_buzzer", 24'(buzzer), 24'h0);
    chk("autostop_hit", 24'(alarm_hit), 24'h0);
    run = 1'b0;

    // Snooze then dismiss.
    do_load(24'h000003);
    run = 1'b1;
    cycles(9);
    chk("ring2", 24'(buzzer), 24'h1);
    snooze = 1'b1;
    cyc();
    chk("snoozed", 24'(buzzer), 24'h0);
    cycles(10);
    chk("snooze_hold", 24'(buzzer), 24'h0);
    cyc();
    chk("snooze_return", 24'(buzzer), 24'h1);
    dismiss = 1'b1;
    cyc();
    chk("dismiss_buzzer", 24'(buzzer), 24'h0);
    chk("dismiss_hit", 24'(alarm_hit), 24'h0);
    run = 1'b0;

    // Two channels on one tick; snooze and dismiss together.
    set_alarm(0, 24'h000010, 1'b1);
    set_alarm(3, 24'h000010, 1'b1);
    do_load(24'h000008);
    run = 1'b1;
    cycles(9);
    chk("dual_hit", 24'(alarm_hit), 24'h9);
    chk("dual_buzzer", 24'(buzzer), 24'h1);
    snooze = 1'b1; dismiss = 1'b1;
    cyc();
    chk("both_pulse_buzzer", 24'(buzzer), 24'h0);
    chk("both_pulse_hit", 24'(alarm_hit), 24'h0);
    cycles(16);
    chk("no_snooze_after_dismiss", 24'(buzzer), 24'h0);
    run = 1'b0;

    // Disabled channel never rings.
    set_alarm(1, 24'h000020, 1'b0);
    set_alarm(6, 24'h000020, 1'b1);
    do_load(24'h000018);
    run = 1'b1;
    cycles(9);
    chk("disabled_buzzer", 24'(buzzer), 24'h0);
    chk("disabled_hit", 24'(alarm_hit), 24'h0);
    cycles(4);
    chk("disabled_later", 24'(buzzer), 24'h0);
    run = 1'b0;

    // Reset while ringing.
    set_alarm(1, 24'h000030, 1'b1);
    do_load(24'h000028);
    run = 1'b1;
    cycles(9);
    chk("ring3", 24'(buzzer), 24'h1);
    do_reset();

    // Random traffic with alarms aimed near the current time.
    for (int n = 0; n < 4000; n++) begin
      run = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) begin
        load = 1'b1;
        time_in = ($urandom_range(0, 3) == 0) ? 24'($urandom) : to_bcd(int'($urandom_range(0, DAY - 1)));
      end
      if ($urandom_range(0, 7) == 0) begin
        alarm_we    = 1'b1;
        alarm_idx   = 3'($urandom_range(0, 7));
        alarm_time  = ($urandom_range(0, 9) == 0) ? 24'($urandom)
                      : to_bcd((m_sec + int'($urandom_range(1, 4))) % DAY);
        alarm_en_in = ($urandom_range(0, 4) != 0);
      end
      snooze  = ($urandom_range(0, 29) == 0);
      dismiss = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 999) == 0) do_reset();
      else cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_alarm_multi.md
CLK_ALARM_MULTI -- requirements
Module: clk_alarm_multi

Interface
REQ-001 Parameter CNT_MAX, default 49999999, prescaler terminal count (one second = CNT_MAX+1 clk cycles).
REQ-002 Parameter N_ALARM, default 4, number of alarm channels, legal range 1..8.
REQ-003 Parameter RING_SEC, default 60, ring duration in seconds before auto-stop.
REQ-004 Parameter SNOOZE_SEC, default 300, snooze duration in seconds.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 run  in  1  level; 1 = timekeeping advances.
REQ-008 load  in  1  one-cycle pulse; loads time_in into the time counters.
REQ-009 time_in  in  24  BCD {h10,h1,m10,m1,s10,s1}, 4 bits per digit.
REQ-010 alarm_we  in  1  one-cycle write strobe for one alarm channel.
REQ-011 alarm_idx  in  3  channel selected by alarm_we; values >= N_ALARM are ignored.
REQ-012 alarm_time  in  24  BCD alarm value, same format as time_in.
REQ-013 alarm_en_in  in  1  enable bit written with alarm_time.
REQ-014 snooze  in  1  one-cycle pulse; snooze request.
REQ-015 dismiss  in  1  one-cycle pulse; stop ringing or snoozing.
REQ-016 time_out  out  24  current time, BCD.
REQ-017 tick  out  1  one-cycle pulse, high in the cycle time_out shows the new second.
REQ-018 buzzer  out  1  high while the alarm is ringing.
REQ-019 alarm_hit  out  N_ALARM  latched per-channel "this alarm fired" flags.
REQ-020 load_err  out  1  one-cycle pulse; the load was rejected.

Function
REQ-021 Prescaler: counts 0..CNT_MAX while run=1, then wraps to 0; it holds its value while run=0.
REQ-022 Second advance: the time counters advance on the edge where prescaler==CNT_MAX and run=1; tick is registered and is high for the following cycle only.
REQ-023 Time counting: 00:00:00..23:59:59; each digit wraps at its BCD limit (s1/m1 at 9, s10/m10 at 5); 23:59:59 advances to 00:00:00; no illegal digit value is ever produced.
REQ-024 Load: load is accepted only if every digit is legal (h<=23, m10,s10<=5, units<=9).
- Accepted load: time_out=time_in on the next edge, prescaler cleared to 0, no tick generated.
- Rejected load: time unchanged, load_err high for one cycle.
REQ-025 Load priority: load has priority over a same-cycle second advance; that advance is discarded.
REQ-026 Alarm write: alarm_we writes alarm_time and alarm_en_in into the channel selected by alarm_idx on the next edge; illegal BCD values are stored but can never match.
REQ-027 Match: channel i matches when tick=1, its enable bit is 1 and time_out equals its alarm value; a load never produces a match.
REQ-028 FSM states: IDLE, RING, SNOOZE.
- IDLE: any match -> RING.
- RING: dismiss -> IDLE; snooze -> SNOOZE; RING_SEC ticks counted in RING -> IDLE (auto-stop).
- SNOOZE: SNOOZE_SEC ticks counted -> RING; dismiss -> IDLE; new match -> RING immediately.
REQ-029 Counters: the ring counter reloads on every entry to RING; the snooze counter loads on entry to SNOOZE; both count ticks only.
REQ-030 Buzzer timing: buzzer is registered, equals (state==RING), and rises the cycle after the matching tick cycle.
REQ-031 alarm_hit: matching channel bits OR into alarm_hit in any state; a match while in RING does not restart the ring counter; alarm_hit clears on dismiss and on auto-stop.
REQ-032 Simultaneous pulses: dismiss and snooze in the same cycle -> dismiss wins.
REQ-033 Simultaneous alarms: several channels matching on one tick set all their alarm_hit bits together.
REQ-034 Independence: alarm_we, load and run changes do not alter FSM state or alarm_hit; run=0 freezes the ring and snooze counters.

Reset
REQ-035 rst=1 sets, asynchronously:
- prescaler, time counters, time_out = 0;
- tick = 0, buzzer = 0, load_err = 0;
- all alarm values and enable bits = 0;
- alarm_hit = 0;
- FSM = IDLE, ring and snooze counters = 0.
REQ-036 Reset asserted mid-ring or mid-snooze returns the block to IDLE with no residual buzzer.

Verification (CNT_MAX=3, RING_SEC=4, SNOOZE_SEC=3, N_ALARM=4)
REQ-037 Rollover: load 23:59:58, run=1 -> after 2 ticks time_out=00:00:00 (0x000000); tick period is 4 cycles.
REQ-038 Bad load: load 0x246000 -> load_err pulses, time_out unchanged; load 0x123059 -> time_out=0x123059 next cycle.
REQ-039 Alarm fire: channel 2 = 0x000005, enabled; start at 0x000003 -> buzzer rises the cycle after the tick showing 0x000005; alarm_hit=4'b0100; buzzer falls after 4 more ticks and alarm_hit clears.
REQ-040 Snooze: while ringing, snooze pulse -> buzzer 0; after 3 ticks buzzer 1 again; then dismiss -> IDLE, alarm_hit=0.
REQ-041 Simultaneous events: channels 0 and 3 both set to the same time -> alarm_hit=4'b1001; snooze and dismiss in one cycle -> IDLE.
REQ-042 Disabled alarm: a disabled channel whose value equals the time never rings.
REQ-043 Reset during ring: rst pulse while ringing -> buzzer=0 and all alarms cleared immediately.
